// File: rtl/bb_msg_scheduler_if.sv
// Write side of the CPU message FIFO as seen by the bounding-box message scheduler,
// including the word count used for the room check and the shared FIFO clear.
interface bb_msg_scheduler_if;
    logic        fifo_wr;
    logic [31:0] fifo_data;
    logic [7:0]  fifo_usedw;
    logic        flush;

    modport master (output fifo_wr, fifo_data, input fifo_usedw, flush);
    modport slave  (input fifo_wr, fifo_data, output fifo_usedw, flush);
endinterface

// File: rtl/bb_msg_scheduler.sv
// Every `interval` frames, snapshots the enabled and valid colour boxes and streams
// a frame header plus three words per reported box into the CPU message FIFO.
module bb_msg_scheduler #(
    parameter int NUM_BOX      = 5,
    parameter int FIFO_DEPTH   = 256,
    parameter int DEF_INTERVAL = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_end,
    input  logic [NUM_BOX*40-1:0] bb_data,
    input  logic [NUM_BOX-1:0]    bb_valid,
    input  logic [NUM_BOX-1:0]    en_mask,
    input  logic [7:0]            interval,
    bb_msg_scheduler_if.master    fifo,
    output logic                  busy,
    output logic [15:0]           drop_cnt
);

    localparam int IW = $clog2(NUM_BOX + 1);

    // DEF_INTERVAL is the reset value of the CPU register that drives `interval`.
    if (DEF_INTERVAL < 1 || DEF_INTERVAL > 255) begin : g_def_interval_check
        $error("bb_msg_scheduler: DEF_INTERVAL must be in 1..255");
    end

    typedef enum logic [2:0] {IDLE, HDR, SCAN, ID, TL, BR} state_t;

    state_t                state, state_next;
    logic [IW-1:0]         idx, idx_next;
    logic [7:0]            frame_cnt;
    logic [15:0]           frame_seq;
    logic [NUM_BOX*40-1:0] bb_snap;
    logic [NUM_BOX-1:0]    sel_snap;
    logic [31:0]           data_q, data_next;

    logic [NUM_BOX-1:0]    sel;
    logic [IW-1:0]         k;
    logic [8:0]            need;
    logic [8:0]            room_sum;
    logic [39:0]           cur_box;
    logic                  due, launch;

    assign sel = en_mask & bb_valid;

    always_comb begin
        k = '0;
        for (int i = 0; i < NUM_BOX; i++) k = k + IW'(sel[i]);
    end

    assign need     = 9'd1 + 9'd3 * 9'(k);
    assign room_sum = {1'b0, fifo.fifo_usedw} + need;
    assign due      = frame_end && (frame_cnt == 8'd0);
    assign launch   = due && (state == IDLE) && !fifo.flush && (room_sum < 9'(FIFO_DEPTH));
    assign cur_box  = bb_snap[int'(idx) * 40 +: 40];

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // The output word is prepared on the transition into each write state so that
    // fifo_data is a register yet valid in the same cycle as fifo_wr.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        data_next  = data_q;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_next = HDR;
                    data_next  = {8'h46, 8'h00, frame_seq};
                end
            end
            HDR: begin
                idx_next   = '0;
                state_next = SCAN;
            end
            SCAN: begin
                if (idx == IW'(NUM_BOX)) begin
                    state_next = IDLE;
                end else if (sel_snap[idx]) begin
                    state_next = ID;
                    data_next  = {8'h00, 8'h42, 8'h42, 8'h30 + 8'(idx)};
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            ID: begin
                state_next = TL;
                data_next  = {6'b0, cur_box[9:0], 6'b0, cur_box[19:10]};
            end
            TL: begin
                state_next = BR;
                data_next  = {6'b0, cur_box[29:20], 6'b0, cur_box[39:30]};
            end
            BR: begin
                idx_next   = idx + 1'b1;
                state_next = SCAN;
            end
            default: state_next = IDLE;
        endcase
        if (fifo.flush) begin
            state_next = IDLE;
            data_next  = data_q;
        end
    end

    // A due report that cannot launch leaves frame_cnt at zero so it retries next frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx       <= '0;
            frame_cnt <= 8'd0;
            frame_seq <= 16'd0;
            drop_cnt  <= 16'd0;
            data_q    <= 32'd0;
            bb_snap   <= '0;
            sel_snap  <= '0;
        end else begin
            idx    <= idx_next;
            data_q <= data_next;
            if (frame_end) begin
                frame_seq <= frame_seq + 16'd1;
                if (frame_cnt != 8'd0)
                    frame_cnt <= frame_cnt - 8'd1;
                else if (launch)
                    frame_cnt <= (interval == 8'd0) ? 8'd0 : interval - 8'd1;
                else if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
            if (launch) begin
                bb_snap  <= bb_data;
                sel_snap <= sel;
            end
        end
    end

    assign fifo.fifo_wr   = state inside {HDR, ID, TL, BR};
    assign fifo.fifo_data = data_q;
    assign busy           = (state != IDLE);

endmodule
